// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one data_memory_system port between two requesters with round-robin
// arbitration. The winning request is latched and held on the memory strobes
// until Stall drops, then read data and a one-cycle ack go back to the owner.
// A saturating stall counter raises a sticky flag when an access hangs.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  rst_n,

  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,

  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,

  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] WordAddress,
  output logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  Stall,
  input  logic [DATA_WIDTH-1:0] DataOut,

  output logic                  busy,
  output logic                  grant_id,
  output logic                  timeout_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);

  state_t                r_state;
  logic                  r_lastGrant;
  logic [CNT_WIDTH-1:0]  r_stallCnt;

  logic                  w_elig0;
  logic                  w_elig1;
  logic                  w_anyElig;
  logic                  w_winner;
  logic                  w_winWe;
  logic [ADDR_WIDTH-1:0] w_winAddr;
  logic [DATA_WIDTH-1:0] w_winWdata;
  logic                  w_grant;
  logic                  w_complete;
  logic [CNT_WIDTH-1:0]  w_stallCntNext;

  // Pick a winner among eligible requesters; a requester being acked this
  // cycle sits out so it has one cycle to drop or change its request.
  always_comb begin
    w_elig0   = req0 & ~ack0;
    w_elig1   = req1 & ~ack1;
    w_anyElig = w_elig0 | w_elig1;
    if (w_elig0 && w_elig1) begin
      w_winner = ~r_lastGrant;
    end else begin
      w_winner = w_elig1;
    end
    w_winWe    = w_winner ? we1    : we0;
    w_winAddr  = w_winner ? addr1  : addr0;
    w_winWdata = w_winner ? wdata1 : wdata0;
    w_grant    = (r_state == ST_IDLE) && w_anyElig;
    w_complete = (r_state == ST_BUSY) && !Stall;
  end

  // Next stall count, pinned at the counter maximum instead of wrapping.
  always_comb begin
    w_stallCntNext = r_stallCnt;
    if (r_stallCnt != CNT_MAX) begin
      w_stallCntNext = r_stallCnt + CNT_WIDTH'(1);
    end
  end

  // Access FSM: grant in IDLE, hold strobes in BUSY until the memory is ready.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lastGrant <= 1'b1;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            MemRead  <= ~w_winWe;
            MemWrite <= w_winWe;
            grant_id <= w_winner;
            busy     <= 1'b1;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_complete) begin
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            busy        <= 1'b0;
            r_lastGrant <= grant_id;
            r_state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Capture the winner's address and write data; they stay put through BUSY.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      WordAddress <= '0;
      DataIn      <= '0;
    end else if (w_grant) begin
      WordAddress <= w_winAddr;
      DataIn      <= w_winWdata;
    end
  end

  // Return path: one-cycle ack to the owner, read data captured only for reads.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (w_complete) begin
        if (grant_id) begin
          ack1 <= 1'b1;
          if (MemRead) begin
            rdata1 <= DataOut;
          end
        end else begin
          ack0 <= 1'b1;
          if (MemRead) begin
            rdata0 <= DataOut;
          end
        end
      end
    end
  end

  // Stall watchdog: count stalled edges of the current access and latch the
  // error flag once the limit is reached; the access itself keeps waiting.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_stallCnt  <= '0;
      timeout_err <= 1'b0;
    end else if (w_grant) begin
      r_stallCnt <= '0;
    end else if ((r_state == ST_BUSY) && Stall) begin
      r_stallCnt <= w_stallCntNext;
      if (w_stallCntNext >= CNT_LIMIT) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Scoreboard bench: each issued request pushes the ack owner and the rdata
// value it should return; every ack pops one entry and compares against it.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int DW         = 32;
  localparam int AW         = 10;
  localparam int TO         = 64;
  localparam int CW         = 8;
  localparam int WAIT_LIMIT = 200;

  logic          CLK = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          MemRead, MemWrite;
  logic [AW-1:0] WordAddress;
  logic [DW-1:0] DataIn;
  logic          Stall;
  logic [DW-1:0] DataOut;
  logic          busy, grant_id, timeout_err;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sbQ[$];
  int            nChecks = 0;
  int            nFails  = 0;
  logic [DW-1:0] modelRdata0;
  logic [DW-1:0] modelRdata1;

  mem_port_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .req0       (req0),
    .we0        (we0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .ack0       (ack0),
    .rdata0     (rdata0),
    .req1       (req1),
    .we1        (we1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .ack1       (ack1),
    .rdata1     (rdata1),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .WordAddress(WordAddress),
    .DataIn     (DataIn),
    .Stall      (Stall),
    .DataOut    (DataOut),
    .busy       (busy),
    .grant_id   (grant_id),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Records the rdata value the owner should see when its ack arrives.
  task automatic push_expected(input logic id, input logic isRead, input logic [DW-1:0] rd);
    exp_t e;
    if (isRead) begin
      if (id) modelRdata1 = rd;
      else    modelRdata0 = rd;
    end
    e.id   = id;
    e.data = id ? modelRdata1 : modelRdata0;
    sbQ.push_back(e);
  endtask

  task automatic clear_model();
    modelRdata0 = '0;
    modelRdata1 = '0;
    sbQ.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    Stall = 1'b0; DataOut = '0;
    tick();
    tick();
    nChecks++;
    if ({MemRead, MemWrite, busy, grant_id, timeout_err, ack0, ack1} !== 7'b0) begin
      nFails++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 0000000",
               {MemRead, MemWrite, busy, grant_id, timeout_err, ack0, ack1});
    end
    nChecks++;
    if (WordAddress !== '0 || DataIn !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_bus: got addr %h data %h, expected 0 0", WordAddress, DataIn);
    end
    nChecks++;
    if (rdata0 !== '0 || rdata1 !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_rdata: got %h %h, expected 0 0", rdata0, rdata1);
    end
    rst_n = 1'b1;
    clear_model();
    tick();
    nChecks++;
    if (busy !== 1'b0 || MemRead !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL idle_no_req: got busy %b rd %b, expected 0 0", busy, MemRead);
    end
  endtask

  task automatic test_single_read();
    int            waited;
    exp_t          e;
    logic [DW-1:0] obs;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005; wdata0 = 32'hFFFF0000;
    Stall = 1'b0; DataOut = 32'hDEADBEEF;
    push_expected(1'b0, 1'b1, 32'hDEADBEEF);
    tick();
    nChecks++;
    if (MemRead !== 1'b1 || MemWrite !== 1'b0 || WordAddress !== 10'h005 ||
        busy !== 1'b1 || grant_id !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL read_grant: got rd %b wr %b addr %h busy %b gid %b, expected 1 0 005 1 0",
               MemRead, MemWrite, WordAddress, busy, grant_id);
    end
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(ack0 || ack1) && waited < WAIT_LIMIT);
    nChecks++;
    if (waited != 1) begin
      nFails++;
      $display("[TB] FAIL read_latency: got %0d cycles, expected 1", waited);
    end
    if (!(ack0 || ack1) || sbQ.size() == 0) begin
      nChecks++; nFails++;
      $display("[TB] FAIL read_ack: got no matching ack, expected ack0");
    end else begin
      e   = sbQ.pop_front();
      obs = ack1 ? rdata1 : rdata0;
      nChecks++;
      if (ack1 !== e.id || ack0 === ack1) begin
        nFails++;
        $display("[TB] FAIL read_ack_id: got ack0 %b ack1 %b, expected owner %0d", ack0, ack1, e.id);
      end
      nChecks++;
      if (obs !== e.data) begin
        nFails++;
        $display("[TB] FAIL read_rdata: got %h, expected %h", obs, e.data);
      end
      nChecks++;
      if (MemRead !== 1'b0 || busy !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL read_release: got rd %b busy %b, expected 0 0", MemRead, busy);
      end
    end
    req0 = 1'b0;
    tick();
    nChecks++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL read_ack_width: got ack0 %b ack1 %b, expected 0 0", ack0, ack1);
    end
  endtask

  task automatic test_write_stall();
    int            waited;
    int            highCycles;
    exp_t          e;
    logic [DW-1:0] obs;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h3FF; wdata1 = 32'h12345678;
    Stall = 1'b1; DataOut = 32'hCCCCCCCC;
    push_expected(1'b1, 1'b0, '0);
    highCycles = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (MemWrite === 1'b1 && MemRead === 1'b0 && DataIn === 32'h12345678 &&
          WordAddress === 10'h3FF && ack1 === 1'b0)
        highCycles++;
      if (i == 1) begin
        addr1 = 10'h001; wdata1 = 32'h0; we1 = 1'b0;
      end
      if (i < 4) tick();
    end
    nChecks++;
    if (highCycles != 5) begin
      nFails++;
      $display("[TB] FAIL write_hold: got %0d held cycles, expected 5", highCycles);
    end
    Stall = 1'b0;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(ack0 || ack1) && waited < WAIT_LIMIT);
    nChecks++;
    if (waited != 1) begin
      nFails++;
      $display("[TB] FAIL write_latency: got %0d cycles after Stall fell, expected 1", waited);
    end
    if (!(ack0 || ack1) || sbQ.size() == 0) begin
      nChecks++; nFails++;
      $display("[TB] FAIL write_ack: got no matching ack, expected ack1");
    end else begin
      e   = sbQ.pop_front();
      obs = ack1 ? rdata1 : rdata0;
      nChecks++;
      if (ack1 !== e.id || ack0 === ack1) begin
        nFails++;
        $display("[TB] FAIL write_ack_id: got ack0 %b ack1 %b, expected owner %0d", ack0, ack1, e.id);
      end
      nChecks++;
      if (obs !== e.data || MemWrite !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL write_rdata: got %h wr %b, expected %h 0", obs, MemWrite, e.data);
      end
    end
    req1 = 1'b0;
    tick();
    nChecks++;
    if (ack1 !== 1'b0 || busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL write_ack_width: got ack1 %b busy %b, expected 0 0", ack1, busy);
    end
  endtask

  task automatic test_round_robin();
    int            waited;
    exp_t          e;
    logic [DW-1:0] obs;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_model();
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h011; wdata0 = 32'h0000AAAA;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h022; wdata1 = 32'h0;
    Stall = 1'b0; DataOut = 32'hA5A50001;
    push_expected(1'b0, 1'b0, '0);
    push_expected(1'b1, 1'b1, 32'hA5A50001);
    push_expected(1'b0, 1'b0, '0);
    push_expected(1'b1, 1'b1, 32'hA5A50001);
    for (int n = 0; n < 4; n++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!(ack0 || ack1) && waited < WAIT_LIMIT);
      if (!(ack0 || ack1) || sbQ.size() == 0) begin
        nChecks++; nFails++;
        $display("[TB] FAIL rr_ack_%0d: got no matching ack, expected one", n);
      end else begin
        e   = sbQ.pop_front();
        obs = ack1 ? rdata1 : rdata0;
        nChecks++;
        if (ack1 !== e.id || ack0 === ack1) begin
          nFails++;
          $display("[TB] FAIL rr_order_%0d: got ack0 %b ack1 %b, expected owner %0d", n, ack0, ack1, e.id);
        end
        nChecks++;
        if (obs !== e.data) begin
          nFails++;
          $display("[TB] FAIL rr_rdata_%0d: got %h, expected %h", n, obs, e.data);
        end
      end
      if (n == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      tick();
      nChecks++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL rr_ack_width_%0d: got ack0 %b ack1 %b, expected 0 0", n, ack0, ack1);
      end
    end
    tick();
    nChecks++;
    if (busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL rr_drain: got busy %b, expected 0", busy);
    end
  endtask

  task automatic test_held_request();
    int   busyCycles;
    int   ackCycles;
    exp_t e;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h010; Stall = 1'b0; DataOut = 32'h0BADF00D;
    push_expected(1'b0, 1'b1, 32'h0BADF00D);
    busyCycles = 0;
    ackCycles  = 0;
    tick();
    busyCycles += int'(busy);
    tick();
    busyCycles += int'(busy);
    ackCycles  += int'(ack0);
    nChecks++;
    if (ack0 !== 1'b1 || busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL held_ack_cycle: got ack0 %b busy %b, expected 1 0", ack0, busy);
    end
    if (ack0 === 1'b1 && sbQ.size() != 0) begin
      e = sbQ.pop_front();
      nChecks++;
      if (rdata0 !== e.data) begin
        nFails++;
        $display("[TB] FAIL held_rdata: got %h, expected %h", rdata0, e.data);
      end
    end
    tick();
    busyCycles += int'(busy);
    ackCycles  += int'(ack0);
    req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      busyCycles += int'(busy);
      ackCycles  += int'(ack0);
    end
    nChecks++;
    if (busyCycles != 1) begin
      nFails++;
      $display("[TB] FAIL held_accesses: got %0d busy cycles, expected 1", busyCycles);
    end
    nChecks++;
    if (ackCycles != 1) begin
      nFails++;
      $display("[TB] FAIL held_acks: got %0d acks, expected 1", ackCycles);
    end
  endtask

  task automatic test_watchdog();
    int            waited;
    exp_t          e;
    logic          expErr;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h0AA; DataOut = 32'h600DCAFE; Stall = 1'b1;
    push_expected(1'b1, 1'b1, 32'h600DCAFE);
    tick();
    nChecks++;
    if (busy !== 1'b1 || MemRead !== 1'b1 || timeout_err !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL wd_grant: got busy %b rd %b err %b, expected 1 1 0", busy, MemRead, timeout_err);
    end
    for (int n = 1; n <= 70; n++) begin
      tick();
      expErr = (n >= TO);
      nChecks++;
      if (timeout_err !== expErr || busy !== 1'b1 || ack1 !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL wd_stall_%0d: got err %b busy %b ack1 %b, expected %b 1 0",
                 n, timeout_err, busy, ack1, expErr);
      end
    end
    Stall = 1'b0;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(ack0 || ack1) && waited < WAIT_LIMIT);
    if (!(ack0 || ack1) || sbQ.size() == 0) begin
      nChecks++; nFails++;
      $display("[TB] FAIL wd_ack: got no matching ack, expected ack1");
    end else begin
      e = sbQ.pop_front();
      nChecks++;
      if (ack1 !== e.id || ack0 === ack1 || rdata1 !== e.data) begin
        nFails++;
        $display("[TB] FAIL wd_ack_data: got ack1 %b rdata1 %h, expected %b %h", ack1, rdata1, e.id, e.data);
      end
    end
    req1 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    nChecks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL wd_sticky: got err %b busy %b, expected 1 0", timeout_err, busy);
    end
  endtask

  task automatic test_reset_mid_access();
    int            waited;
    int            ackSeen;
    exp_t          e;
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h123; wdata0 = 32'h55AA55AA; Stall = 1'b1;
    tick();
    nChecks++;
    if (busy !== 1'b1 || MemWrite !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL mid_grant: got busy %b wr %b, expected 1 1", busy, MemWrite);
    end
    tick();
    tick();
    rst_n = 1'b0;
    req0  = 1'b0;
    tick();
    nChecks++;
    if ({MemRead, MemWrite, busy, grant_id, timeout_err, ack0, ack1} !== 7'b0 ||
        WordAddress !== '0 || DataIn !== '0 || rdata0 !== '0 || rdata1 !== '0) begin
      nFails++;
      $display("[TB] FAIL mid_reset: got ctrl %b addr %h data %h rd0 %h rd1 %h, expected all 0",
               {MemRead, MemWrite, busy, grant_id, timeout_err, ack0, ack1},
               WordAddress, DataIn, rdata0, rdata1);
    end
    rst_n = 1'b1;
    Stall = 1'b0;
    clear_model();
    ackSeen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack0 === 1'b1 || ack1 === 1'b1 || busy === 1'b1) ackSeen++;
    end
    nChecks++;
    if (ackSeen != 0) begin
      nFails++;
      $display("[TB] FAIL mid_no_ack: got %0d active cycles, expected 0", ackSeen);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h001;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h002;
    DataOut = 32'h13572468;
    push_expected(1'b0, 1'b1, 32'h13572468);
    tick();
    nChecks++;
    if (grant_id !== 1'b0 || busy !== 1'b1 || WordAddress !== 10'h001) begin
      nFails++;
      $display("[TB] FAIL mid_tie_winner: got gid %b busy %b addr %h, expected 0 1 001",
               grant_id, busy, WordAddress);
    end
    for (int n = 0; n < 2; n++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!(ack0 || ack1) && waited < WAIT_LIMIT);
      if (!(ack0 || ack1) || sbQ.size() == 0) begin
        nChecks++; nFails++;
        $display("[TB] FAIL mid_ack_%0d: got no matching ack, expected one", n);
      end else begin
        e = sbQ.pop_front();
        nChecks++;
        if (ack1 !== e.id || ack0 === ack1 || (e.id ? rdata1 : rdata0) !== e.data) begin
          nFails++;
          $display("[TB] FAIL mid_ack_data_%0d: got ack0 %b ack1 %b rd0 %h rd1 %h, expected owner %0d data %h",
                   n, ack0, ack1, rdata0, rdata1, e.id, e.data);
        end
        if (e.id == 1'b0) begin
          req0 = 1'b0;
          DataOut = 32'h24681357;
          push_expected(1'b1, 1'b1, 32'h24681357);
        end else begin
          req1 = 1'b0;
        end
      end
    end
    tick();
    tick();
    nChecks++;
    if (busy !== 1'b0 || rdata0 !== modelRdata0 || rdata1 !== modelRdata1) begin
      nFails++;
      $display("[TB] FAIL mid_final: got busy %b rd0 %h rd1 %h, expected 0 %h %h",
               busy, rdata0, rdata1, modelRdata0, modelRdata1);
    end
  endtask

  initial begin
    $display("[TB] starting mem_port_arbiter bench");
    test_reset();
    test_single_read();
    test_write_stall();
    test_round_robin();
    test_held_request();
    test_watchdog();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester round-robin arbiter that shares one data_memory_system port between two masters, e.g. a load/store unit and a DMA/debug port. It latches the winning request, drives MemRead/MemWrite/WordAddress/DataIn to the memory system, and holds them until Stall drops. It then returns read data and a one-cycle ack to the granted requester. A saturating stall watchdog flags accesses that hang.

Parameters:
DATA_WIDTH, 32, data word width; matches the memory system.
ADDR_WIDTH, 10, word address width; matches the memory system.
TIMEOUT, 64, stall cycles within one access before timeout_err sets; must be at least 2.
CNT_WIDTH, 8, stall counter width; 2^CNT_WIDTH-1 must be at least TIMEOUT.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
rst_n  input  1  synchronous reset, active-low.
req0  input  1  requester 0 access request; held until ack0.
we0  input  1  requester 0 op: 1=write, 0=read.
addr0  input  ADDR_WIDTH  requester 0 word address.
wdata0  input  DATA_WIDTH  requester 0 write data.
ack0  output  1  one-cycle completion pulse to requester 0.
rdata0  output  DATA_WIDTH  read data to requester 0; valid while ack0=1.
req1, we1, addr1, wdata1, ack1, rdata1  same as above, for requester 1.
MemRead  output  1  read strobe to memory system.
MemWrite  output  1  write strobe to memory system.
WordAddress  output  ADDR_WIDTH  latched access address.
DataIn  output  DATA_WIDTH  latched write data.
Stall  input  1  memory system not ready; access is not complete while 1.
DataOut  input  DATA_WIDTH  memory read data; sampled at completion.
busy  output  1  1 while in BUSY.
grant_id  output  1  requester owning the current or last access.
timeout_err  output  1  sticky watchdog flag.

Behaviour:
- Reset, applied on the edge where rst_n=0, sets every output to 0:
  - state=IDLE, MemRead=MemWrite=0, WordAddress=0, DataIn=0.
  - ack0=ack1=0, rdata0=rdata1=0, busy=0, grant_id=0, timeout_err=0, stall_cnt=0.
  - last_grant=1, so requester 0 wins the first tie.
- Reset mid-access abandons the access. No ack is issued and the strobes are low after that edge.
- All outputs are registered.
- Eligibility in IDLE: reqN counts only if ackN=0 in that cycle. This gives the requester one cycle to drop or change its request.
- IDLE:
  - No eligible request: stay in IDLE.
  - Exactly one eligible request: grant it.
  - Both eligible: grant the requester that is not last_grant.
  - On the grant edge:
    - Latch addr/wdata into WordAddress/DataIn.
    - MemRead=~we, MemWrite=we.
    - grant_id=winner, busy=1, stall_cnt=0, go to BUSY.
- BUSY:
  - Strobes, WordAddress and DataIn are held constant.
  - Completion is the first edge in BUSY where Stall=0.
  - On the completion edge:
    - MemRead=MemWrite=0, busy=0, last_grant=grant_id, go to IDLE.
    - ack[grant_id]=1 for exactly one cycle.
    - For a read: rdata[grant_id]=DataOut. For a write: rdata is unchanged.
  - Each edge in BUSY with Stall=1: stall_cnt increments, saturating at 2^CNT_WIDTH-1.
  - When stall_cnt reaches TIMEOUT, timeout_err=1.
  - timeout_err is cleared only by reset. The access keeps waiting; there is no abort.
- Minimum latency:
  - req high at edge k → grant at edge k.
  - Completion at edge k+1 when Stall=0, so ack is high in cycle k+1.
  - Back-to-back grants to the same requester are at least 2 edges apart.
- Requester inputs are ignored while in BUSY; changes in BUSY do not affect the latched access.
- ack0 and ack1 are never high in the same cycle.
- rdataN holds its value until the next read completion for that requester.
- Stall in IDLE is ignored.
- DataOut is sampled only at read completion.

Test Plan:
1. Single read, no stall:
   - Stimulus: req0=1, we0=0, addr0=0x005; Stall=0; DataOut=0xDEADBEEF.
   - Response: MemRead=1 and WordAddress=0x005 for 1 cycle; next cycle ack0=1 and rdata0=0xDEADBEEF; ack1 stays 0.
2. Write with miss stall:
   - Stimulus: req1=1, we1=1, addr1=0x3FF, wdata1=0x12345678; Stall=1 for 4 cycles after grant.
   - Response: MemWrite=1 and DataIn=0x12345678 held 5 cycles; ack1 pulses once after Stall falls; rdata1 unchanged.
3. Round-robin contention:
   - Stimulus: req0 and req1 both held high continuously, Stall=0.
   - Response: grant order after reset is 0, 1, 0, 1; each ack is exactly 1 cycle; no requester is served twice in a row.
4. Held request after ack:
   - Stimulus: req0 stays high during the ack0 cycle, then drops.
   - Response: only one access is issued; busy=0 in the ack cycle.
5. Watchdog:
   - Stimulus: TIMEOUT=64, Stall held 1 for 70 cycles, then 0.
   - Response: timeout_err=1 from the 64th stalled edge; ack delivered after Stall falls; timeout_err stays 1 until rst_n=0.
6. Reset mid-access:
   - Stimulus: rst_n=0 for one cycle during BUSY with Stall=1.
   - Response: next cycle all outputs are 0, no ack is issued, and req0 is the next winner on a tie.
